y86_bus_arbiter: RTL and testbench
==================================

Name: y86_bus_arbiter

Overview:
- Shares the single y86 memory bus (bus_A/bus_in/bus_out/bus_WE/bus_RE) between two requesters: master 0 (y86_seq core) and master 1 (DMA/debug loader).
- Registered three-state FSM: latches one request, drives the bus for a fixed number of wait states, captures read data, then returns a one-cycle ack to the owner.
- Sits between the core and the memory model; the core's bus strobes become m0 requests.

Parameters:
- ADDR_W, 32, address width of masters and bus_A
- DATA_W, 32, data width of wdata/rdata/bus_in/bus_out
- WAIT_STATES, 1, extra XFER cycles per access; legal range 0..15; XFER lasts WAIT_STATES+1 cycles

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  master 0 request (level)
- m0_we  in  1  master 0: 1=write, 0=read
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack on reads
- m0_ack  out  1  master 0 completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0, for master 1
- bus_A  out  ADDR_W  memory address
- bus_in  in  DATA_W  memory read data
- bus_out  out  DATA_W  memory write data
- bus_WE  out  1  memory write strobe
- bus_RE  out  1  memory read strobe
- busy  out  1  high in XFER or RESP
- owner  out  1  index of current or last granted master

Behaviour:
- Reset (async): state=IDLE, wait counter=0, owner=0, last_grant=1, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, bus_A=0, bus_out=0, bus_WE=bus_RE=0, busy=0. Reset mid-transaction aborts it: strobes drop immediately, no ack issued.
- All outputs are registers or decodes of registered state; no combinational path from req to any output.
- IDLE: if no req, stay. Else select per arbitration policy; latch addr, wdata, we, owner; load counter=WAIT_STATES; go XFER.
- XFER: bus_A=latched addr; bus_RE=!we; bus_WE=we; bus_out=wdata on writes, 0 on reads. Counter decrements each cycle. At counter==0: on reads capture bus_in into owner's rdata; go RESP.
- RESP: strobes low, bus_A=0; owner's ack=1 for exactly this cycle; go IDLE.
- Latency: req sampled in IDLE in cycle 0 -> XFER cycles 1..WAIT_STATES+1 -> ack in cycle WAIT_STATES+2. Back-to-back grants: new XFER starts in cycle WAIT_STATES+4 at earliest.
- Request contract:
  - Master holds req/addr/wdata/we stable until its ack.
  - Master must drop req in the cycle after ack unless it wants another access; req high in IDLE always starts a new transaction.
  - req dropped during XFER is ignored; the transaction completes and ack still pulses.
- Arbitration (default, fixed priority): m0 wins when both request in the same IDLE cycle. The loser keeps req high and is granted in the next IDLE in which m0_req is low.
- rdata of a master holds its value until that master's next read completes; writes leave it unchanged.
- owner updates only on grant; last_grant=owner after each grant.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant goes to the master != last_grant. After reset last_grant=1, so m0 wins the first tie. A single requester is always granted regardless of last_grant.
- Undefined: fixed priority, m0 always wins ties; m1 can starve if m0 requests continuously. last_grant is still tracked but unused.

Test Plan:
- Reset then m0 read, WAIT_STATES=1, addr 0x10, memory returns 0xDEADBEEF: bus_RE=1 and bus_A=0x10 for cycles 1-2; m0_ack in cycle 3; m0_rdata=0xDEADBEEF; bus_WE stays 0.
- m1 write addr 0x20, wdata 0x12345678, WAIT_STATES=0: bus_WE=1, bus_out=0x12345678 for exactly 1 cycle; m1_ack in cycle 2; m1_rdata unchanged; owner=1.
- Both req in same cycle, macro undefined, each drops req after its ack: m0 served first; m1 ack follows; bus_A shows m0_addr then m1_addr; never two acks in one cycle.
- Both req held continuously, ARB_ROUND_ROBIN_EN defined: grant order m0, m1, m0, m1. Same stimulus with macro undefined: m0 only, m1_ack never asserted.
- rst asserted in the middle of an XFER: bus_RE/bus_WE drop without waiting for a clock edge; no ack pulses; state returns to IDLE. After release, a fresh m0 request completes normally.
- m0 drops req during XFER: transaction completes and m0_ack still pulses once; the next IDLE with no req stays idle with busy=0.

Source files
------------

// File: rtl/y86_bus_arbiter.sv
// y86_bus_arbiter
// Shares the single y86 memory bus between two masters: master 0 is the
// y86_seq core and master 1 is the DMA/debug loader. One request is latched
// in IDLE, the bus is driven for WAIT_STATES+1 XFER cycles, read data is
// captured on the last XFER cycle, and the owner gets a one-cycle ack in RESP.
// Every output comes straight from a flop, so there is no combinational path
// from a request to any output.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req/we/addr/wdata      master N request (level), direction, address, write data
//   mN_rdata, mN_ack          master N read data (valid with ack) and completion pulse
//   bus_A, bus_out            memory address and write data
//   bus_in                    memory read data
//   bus_WE, bus_RE            memory write / read strobes
//   busy                      high while in XFER or RESP
//   owner                     index of the current or most recently granted master
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. Without it master 0 always wins a tie.

module y86_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] bus_A,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_WE,
    output logic              bus_RE,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   bus_a_q, bus_a_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                bus_we_q, bus_we_d;
    logic                bus_re_q, bus_re_d;
    logic                busy_q, busy_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                grant_m1;
    logic                sel_we;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_grant_q, last_grant_d;
`endif

    // Arbitration decision, only meaningful in IDLE with a request pending.
    always_comb begin
        grant_m1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie the master that was not served last wins.
        grant_m1 = m1_req & (~m0_req | ~last_grant_q);
`else
        grant_m1 = m1_req & ~m0_req;
`endif
        sel_we = grant_m1 ? m1_we : m0_we;
    end

    // Next-state and next-output computation. Outputs are computed for the
    // state being entered so they appear registered in that state's cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        bus_a_d    = bus_a_q;
        bus_out_d  = bus_out_q;
        bus_we_d   = bus_we_q;
        bus_re_d   = bus_re_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d   = grant_m1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_m1;
`endif
                    bus_a_d   = grant_m1 ? m1_addr : m0_addr;
                    bus_out_d = sel_we ? (grant_m1 ? m1_wdata : m0_wdata) : '0;
                    bus_we_d  = sel_we;
                    bus_re_d  = ~sel_we;
                    cnt_d     = 4'(WAIT_STATES);
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (cnt_q == 4'd0) begin
                    // Last bus cycle: bus_in is sampled here for reads.
                    if (bus_re_q) begin
                        if (owner_q) begin
                            m1_rdata_d = bus_in;
                        end else begin
                            m0_rdata_d = bus_in;
                        end
                    end
                    if (owner_q) begin
                        m1_ack_d = 1'b1;
                    end else begin
                        m0_ack_d = 1'b1;
                    end
                    bus_a_d   = '0;
                    bus_out_d = '0;
                    bus_we_d  = 1'b0;
                    bus_re_d  = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                bus_a_d  = '0;
                bus_we_d = 1'b0;
                bus_re_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears everything immediately,
    // which also aborts any transfer in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            bus_a_q    <= '0;
            bus_out_q  <= '0;
            bus_we_q   <= 1'b0;
            bus_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            bus_a_q    <= bus_a_d;
            bus_out_q  <= bus_out_d;
            bus_we_q   <= bus_we_d;
            bus_re_q   <= bus_re_d;
            busy_q     <= busy_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus_A    = bus_a_q;
    assign bus_out  = bus_out_q;
    assign bus_WE   = bus_we_q;
    assign bus_RE   = bus_re_q;
    assign busy     = busy_q;
    assign owner    = owner_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// tb_y86_bus_arbiter
// Bench for y86_bus_arbiter with WAIT_STATES=1. Directed scenarios cover
// reset, single reads/writes, ties, continuous contention, reset mid-transfer
// and a request dropped during XFER; a randomized run compares every cycle
// against a transaction-timing model. Tie expectations follow
// ARB_ROUND_ROBIN_EN when it is defined for the build.

module tb_y86_bus_arbiter;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [31:0] bus_A, bus_in, bus_out;
    logic        bus_WE, bus_RE, busy, owner;

    int checks = 0;
    int failures = 0;

    y86_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_A(bus_A), .bus_in(bus_in), .bus_out(bus_out),
        .bus_WE(bus_WE), .bus_RE(bus_RE), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign bus_in = mem_model(bus_A);

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({bus_A, bus_out, bus_WE, bus_RE, busy, owner, m0_ack, m1_ack} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got A=%h out=%h WE=%b RE=%b busy=%b owner=%b ack=%b%b, expected all zero",
                     bus_A, bus_out, bus_WE, bus_RE, busy, owner, m0_ack, m1_ack);
        end
        checks++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_m0_read();
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        for (int c = 1; c <= WS + 3; c++) begin
            @(negedge clk);
            checks++;
            if (c <= WS + 1) begin
                if (bus_RE !== 1 || bus_WE !== 0 || bus_A !== 32'h10 || m0_ack !== 0 || owner !== 0) begin
                    failures++;
                    $display("[TB] FAIL m0_read_xfer c%0d: got RE=%b WE=%b A=%h ack=%b owner=%b expected 1 0 00000010 0 0",
                             c, bus_RE, bus_WE, bus_A, m0_ack, owner);
                end
            end else if (c == WS + 2) begin
                if (m0_ack !== 1 || bus_RE !== 0 || bus_WE !== 0 || m0_rdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("[TB] FAIL m0_read_ack: got ack=%b RE=%b WE=%b rdata=%h expected 1 0 0 deadbeef",
                             m0_ack, bus_RE, bus_WE, m0_rdata);
                end
                m0_req = 0;
            end else begin
                if (m0_ack !== 0 || busy !== 0) begin
                    failures++;
                    $display("[TB] FAIL m0_read_after: got ack=%b busy=%b expected 0 0", m0_ack, busy);
                end
            end
        end
    endtask

    task automatic test_m1_write();
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        for (int c = 1; c <= WS + 2; c++) begin
            @(negedge clk);
            checks++;
            if (c <= WS + 1) begin
                if (bus_WE !== 1 || bus_RE !== 0 || bus_out !== 32'h12345678 || bus_A !== 32'h20 || owner !== 1) begin
                    failures++;
                    $display("[TB] FAIL m1_write_xfer c%0d: got WE=%b RE=%b out=%h A=%h owner=%b expected 1 0 12345678 00000020 1",
                             c, bus_WE, bus_RE, bus_out, bus_A, owner);
                end
            end else begin
                if (m1_ack !== 1 || bus_WE !== 0 || m1_rdata !== 32'h0 || m0_ack !== 0) begin
                    failures++;
                    $display("[TB] FAIL m1_write_ack: got ack1=%b WE=%b rdata1=%h ack0=%b expected 1 0 0 0",
                             m1_ack, bus_WE, m1_rdata, m0_ack);
                end
                m1_req = 0;
            end
        end
    endtask

    // Both request together; each drops after its own ack.
    task automatic test_tie();
        logic [31:0] exp_a;
        logic        exp_ack0, exp_ack1;
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h30;
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hCAFEF00D;
        for (int c = 1; c <= 2 * WS + 6; c++) begin
            @(negedge clk);
            exp_a = (c <= WS + 1) ? 32'h30 : ((c >= WS + 4 && c <= 2 * WS + 4) ? 32'h40 : 32'h0);
            exp_ack0 = (c == WS + 2);
            exp_ack1 = (c == 2 * WS + 5);
            checks++;
            if (bus_A !== exp_a || m0_ack !== exp_ack0 || m1_ack !== exp_ack1) begin
                failures++;
                $display("[TB] FAIL tie c%0d: got A=%h ack0=%b ack1=%b expected %h %b %b",
                         c, bus_A, m0_ack, m1_ack, exp_a, exp_ack0, exp_ack1);
            end
            if (c == WS + 2) m0_req = 0;
            if (c == 2 * WS + 5) m1_req = 0;
        end
        checks++;
        if (m0_rdata !== mem_model(32'h30)) begin
            failures++;
            $display("[TB] FAIL tie_rdata: got %h expected %h", m0_rdata, mem_model(32'h30));
        end
    endtask

    // Both hold requests through four grants.
    task automatic test_held_both();
        int  k, ph;
        logic exp_m, exp_ack0, exp_ack1;
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h50;
        m1_req = 1; m1_we = 0; m1_addr = 32'h60;
        for (int c = 1; c <= 4 * (WS + 3); c++) begin
            @(negedge clk);
            k  = (c - 1) / (WS + 3);
            ph = (c - 1) % (WS + 3) + 1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_m = k[0];
`else
            exp_m = 1'b0;
`endif
            exp_ack0 = (ph == WS + 2) && !exp_m;
            exp_ack1 = (ph == WS + 2) && exp_m;
            checks++;
            if (m0_ack !== exp_ack0 || m1_ack !== exp_ack1) begin
                failures++;
                $display("[TB] FAIL held_both c%0d: got ack0=%b ack1=%b expected %b %b",
                         c, m0_ack, m1_ack, exp_ack0, exp_ack1);
            end
            if (k == 3 && ph == WS + 2) begin
                m0_req = 0;
                m1_req = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h74;
        @(negedge clk);
        checks++;
        if (bus_RE !== 1) begin
            failures++;
            $display("[TB] FAIL reset_mid_setup: got RE=%b expected 1", bus_RE);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({bus_RE, bus_WE, busy, m0_ack} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_drop: got RE=%b WE=%b busy=%b ack=%b expected 0 0 0 0",
                     bus_RE, bus_WE, busy, m0_ack);
        end
        m0_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ((m0_ack | m1_ack) !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_mid_noack: got ack0=%b ack1=%b expected 0 0", m0_ack, m1_ack);
            end
        end
        rst = 0;
        @(negedge clk);
        m0_req = 1;
        for (int c = 1; c <= WS + 2; c++) begin
            @(negedge clk);
            checks++;
            if (c < WS + 2) begin
                if (m0_ack !== 0 || bus_RE !== 1) begin
                    failures++;
                    $display("[TB] FAIL reset_mid_fresh_xfer c%0d: got ack=%b RE=%b expected 0 1", c, m0_ack, bus_RE);
                end
            end else begin
                if (m0_ack !== 1 || m0_rdata !== mem_model(32'h74)) begin
                    failures++;
                    $display("[TB] FAIL reset_mid_fresh_ack: got ack=%b rdata=%h expected 1 %h",
                             m0_ack, m0_rdata, mem_model(32'h74));
                end
                m0_req = 0;
            end
        end
    endtask

    // Request pulses for one cycle only; the write must still complete.
    task automatic test_drop_req();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'h11112222;
        for (int c = 1; c <= WS + 5; c++) begin
            @(negedge clk);
            m0_req = 0;
            checks++;
            if (m0_ack !== (c == WS + 2) || busy !== (c <= WS + 2)) begin
                failures++;
                $display("[TB] FAIL drop_req c%0d: got ack=%b busy=%b expected %b %b",
                         c, m0_ack, busy, (c == WS + 2), (c <= WS + 2));
            end
        end
        checks++;
        if (m0_rdata !== mem_model(32'h74)) begin
            failures++;
            $display("[TB] FAIL drop_req_rdata: got %h expected %h", m0_rdata, mem_model(32'h74));
        end
    endtask

    // Random traffic checked against a transaction-timing model: a grant
    // occupies WS+1 bus cycles, then one ack cycle, then one idle cycle.
    task automatic test_random();
        int          t;
        logic        mown, mlast, cur, cur_we;
        logic [31:0] cur_addr, cur_wd;
        logic        pend [2];
        logic        we_r [2];
        logic [31:0] addr_r [2];
        logic [31:0] wd_r [2];
        logic [31:0] mrd [2];
        logic        xfer;
        logic [71:0] exp_v, got_v;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        t = 0; mown = 0; mlast = 1; cur = 0; cur_we = 0; cur_addr = 0; cur_wd = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; we_r[m] = 0; addr_r[m] = 0; wd_r[m] = 0; mrd[m] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m]   = 1;
                    we_r[m]   = $urandom_range(0, 1) == 1;
                    addr_r[m] = $urandom;
                    wd_r[m]   = $urandom;
                end
            end
            m0_req = pend[0]; m0_we = we_r[0]; m0_addr = addr_r[0]; m0_wdata = wd_r[0];
            m1_req = pend[1]; m1_we = we_r[1]; m1_addr = addr_r[1]; m1_wdata = wd_r[1];
            @(negedge clk);
            if (t == 0) begin
                if (pend[0] || pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    cur = (pend[0] && pend[1]) ? !mlast : pend[1];
`else
                    cur = pend[1] && !pend[0];
`endif
                    mown = cur; mlast = cur;
                    cur_we = we_r[cur]; cur_addr = addr_r[cur]; cur_wd = wd_r[cur];
                    t = 1;
                end
            end else if (t == WS + 2) begin
                t = 0;
            end else begin
                t++;
            end
            if (t == WS + 2 && !cur_we) mrd[cur] = mem_model(cur_addr);
            xfer  = (t >= 1 && t <= WS + 1);
            exp_v = {xfer ? cur_addr : 32'h0, (xfer && cur_we) ? cur_wd : 32'h0,
                     xfer && cur_we, xfer && !cur_we, t != 0, mown,
                     (t == WS + 2) && !cur, (t == WS + 2) && cur, 2'b00};
            got_v = {bus_A, bus_out, bus_WE, bus_RE, busy, owner, m0_ack, m1_ack, 2'b00};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL random_bus cyc%0d: got %h expected %h", cyc, got_v, exp_v);
            end
            checks++;
            if (m0_rdata !== mrd[0] || m1_rdata !== mrd[1]) begin
                failures++;
                $display("[TB] FAIL random_rdata cyc%0d: got %h/%h expected %h/%h",
                         cyc, m0_rdata, m1_rdata, mrd[0], mrd[1]);
            end
            if (t == WS + 2) pend[cur] = 0;
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_m0_read();
        test_m1_write();
        test_tie();
        test_held_both();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
